// File: rtl/trace_line_parser_pkg.sv
// trace_line_parser_pkg: ASCII constants, op encodings, FSM states and character helpers
package trace_line_parser_pkg;
   localparam logic [7:0] CH_LF = 8'h0A;
   localparam logic [7:0] CH_CR = 8'h0D;
   localparam logic [7:0] CH_SP = 8'h20;
   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;
   typedef enum logic [2:0] {ST_IDLE, ST_SEP, ST_DIGITS, ST_TAIL, ST_SKIP} state_t;
   function automatic logic is_hex(input logic [7:0] c);
      return (c >= "0" && c <= "9") || (c >= "A" && c <= "F") || (c >= "a" && c <= "f");
   endfunction
   // letters map via their low nibble plus 9 ('A'/'a' -> 1 + 9)
   function automatic logic [3:0] hex_nib(input logic [7:0] c);
      return (c <= "9") ? c[3:0] : c[3:0] + 4'd9;
   endfunction
   function automatic logic is_op(input logic [7:0] c);
      return c == "R" || c == "r" || c == "W" || c == "w";
   endfunction
   function automatic logic op_of(input logic [7:0] c);
      return (c == "W" || c == "w") ? OP_WRITE : OP_READ;
   endfunction
   function automatic logic is_x(input logic [7:0] c);
      return c == "x" || c == "X";
   endfunction
endpackage

// File: rtl/trace_line_parser_fifo.sv
// trace_line_parser_fifo: synchronous record FIFO; output holds the last popped entry while empty
module trace_line_parser_fifo #(
   parameter int W     = 33,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0] mem_q [DEPTH];
   logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
   logic [W-1:0] last_q, last_d;
   always_comb begin
      empty  = wr_q == rd_q;
      full   = (wr_q - rd_q) == (AW+1)'(DEPTH);
      wr_d   = push ? wr_q + (AW+1)'(1) : wr_q;
      rd_d   = pop ? rd_q + (AW+1)'(1) : rd_q;
      last_d = pop ? mem_q[rd_q[AW-1:0]] : last_q;
      dout   = empty ? last_q : mem_q[rd_q[AW-1:0]];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q   <= '0;
         rd_q   <= '0;
         last_q <= '0;
      end else begin
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         last_q <= last_d;
      end
   end
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/trace_line_parser.sv
// trace_line_parser: decodes "<op> [0x]<hex addr>\n" byte stream into buffered {op, addr} records.
// Define TRACE_STATS_EN to enable the saturating rec_count/err_count statistics.
module trace_line_parser
   import trace_line_parser_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_en,
   input  logic [7:0]        in_byte,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_op,
   output logic [ADDR_W-1:0] out_addr,
   output logic              overflow,
   output logic [15:0]       rec_count,
   output logic [15:0]       err_count
);
   localparam int ND = ADDR_W / 4;
   localparam int CW = $clog2(ND + 1);
   state_t            state_q, state_d, fail_st;
   logic              op_q, op_d;
   logic [ADDR_W-1:0] acc_q, acc_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              overflow_q, overflow_d;
   logic              commit, err, push, pop, full, empty;
   // a malformed byte that is itself '\n' already ends the line
   assign fail_st = (in_byte == CH_LF) ? ST_IDLE : ST_SKIP;
   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      commit  = 1'b0;
      err     = 1'b0;
      if (in_en && in_byte != CH_CR) begin
         case (state_q)
            ST_IDLE:
               if (is_op(in_byte)) begin
                  op_d    = op_of(in_byte);
                  acc_d   = '0;
                  cnt_d   = '0;
                  state_d = ST_SEP;
               end else if (in_byte != CH_SP && in_byte != CH_LF) begin
                  err     = 1'b1;
                  state_d = ST_SKIP;
               end
            ST_SEP:
               if (is_hex(in_byte)) begin
                  acc_d   = ADDR_W'(hex_nib(in_byte));
                  cnt_d   = CW'(1);
                  state_d = ST_DIGITS;
               end else if (in_byte != CH_SP) begin
                  err     = 1'b1;
                  state_d = fail_st;
               end
            ST_DIGITS:
               if (is_hex(in_byte)) begin
                  if (cnt_q == CW'(ND)) begin
                     err     = 1'b1;
                     state_d = ST_SKIP;
                  end else begin
                     acc_d = {acc_q[ADDR_W-5:0], hex_nib(in_byte)};
                     cnt_d = cnt_q + CW'(1);
                  end
               end else if (is_x(in_byte) && cnt_q == CW'(1) && acc_q == '0) begin
                  cnt_d = '0;
               end else if ((in_byte == CH_LF || in_byte == CH_SP) && cnt_q != '0) begin
                  commit  = 1'b1;
                  state_d = (in_byte == CH_LF) ? ST_IDLE : ST_TAIL;
               end else begin
                  err     = 1'b1;
                  state_d = fail_st;
               end
            ST_TAIL:
               state_d = (in_byte == CH_LF) ? ST_IDLE : (in_byte == CH_SP) ? ST_TAIL : ST_SKIP;
            default:
               state_d = (in_byte == CH_LF) ? ST_IDLE : ST_SKIP;
         endcase
      end
      if (flush) begin
         commit  = commit | (state_d == ST_DIGITS && cnt_d != '0);
         state_d = ST_IDLE;
      end
   end
   assign pop        = out_valid & out_ready;
   assign push       = commit & (!full | pop);
   assign overflow_d = overflow_q | (commit & full & !pop);
   assign out_valid  = !empty;
   assign overflow   = overflow_q;
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         op_q       <= 1'b0;
         acc_q      <= '0;
         cnt_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         acc_q      <= acc_d;
         cnt_q      <= cnt_d;
         overflow_q <= overflow_d;
      end
   end
   trace_line_parser_fifo #(.W(ADDR_W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .din   ({op_d, acc_d}),
      .dout  ({out_op, out_addr}),
      .full  (full),
      .empty (empty)
   );
`ifdef TRACE_STATS_EN
   logic [15:0] rec_q, rec_d, errc_q, errc_d;
   always_comb begin
      rec_d  = rec_q + 16'(push && rec_q != 16'hFFFF);
      errc_d = errc_q + 16'(err && errc_q != 16'hFFFF);
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         rec_q  <= '0;
         errc_q <= '0;
      end else begin
         rec_q  <= rec_d;
         errc_q <= errc_d;
      end
   end
   assign rec_count = rec_q;
   assign err_count = errc_q;
`else
   logic unused_err;
   assign unused_err = err;
   assign rec_count  = 16'h0000;
   assign err_count  = 16'h0000;
`endif
endmodule

// File: tb/tb_trace_line_parser.sv
// tb_trace_line_parser: directed trace lines with hand-computed records, errors and overflow.
module tb_trace_line_parser;
   logic        clk = 1'b0;
   logic        rst, in_en, flush, out_ready;
   logic [7:0]  in_byte;
   logic        out_valid, out_op, overflow;
   logic [31:0] out_addr;
   logic [15:0] rec_count, err_count;
`ifdef TRACE_STATS_EN
   localparam bit STATS = 1'b1;
`else
   localparam bit STATS = 1'b0;
`endif
   int total = 0;
   int bad   = 0;

   trace_line_parser #(.ADDR_W(32), .FIFO_DEPTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_en     (in_en),
      .in_byte   (in_byte),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_addr  (out_addr),
      .overflow  (overflow),
      .rec_count (rec_count),
      .err_count (err_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      in_en   = 1'b1;
      in_byte = b;
      step();
      in_en   = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic pop_chk(input string tag, input logic op, input logic [31:0] addr);
      chk({tag, "_valid"}, 64'(out_valid), 64'd1);
      chk({tag, "_op"}, 64'(out_op), 64'(op));
      chk({tag, "_addr"}, 64'(out_addr), 64'(addr));
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
   endtask

   task automatic chk_cnt(input string tag, input int rec, input int errs);
      chk({tag, "_rec"}, 64'(rec_count), STATS ? 64'(rec) : 64'd0);
      chk({tag, "_err"}, 64'(err_count), STATS ? 64'(errs) : 64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      in_en = 1'b0; in_byte = 8'h00; flush = 1'b0; out_ready = 1'b0;
      do_reset();
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_op", 64'(out_op), 64'd0);
      chk("rst_addr", 64'(out_addr), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
      chk_cnt("rst", 0, 0);

      // basic read with 0x prefix; one-cycle latency from '\n'
      send_str("R 0x1A2B3C4D");
      chk("t1_pre_lf", 64'(out_valid), 64'd0);
      send_byte(8'h0A);
      pop_chk("t1", 1'b0, 32'h1A2B3C4D);
      chk("t1_empty", 64'(out_valid), 64'd0);
      chk("t1_hold", 64'(out_addr), 64'h1A2B3C4D);

      // CR ignored, blank line ignored
      send_str("w ff\r\n\nW 0\n");
      pop_chk("t2a", 1'b1, 32'h000000FF);
      pop_chk("t2b", 1'b1, 32'h0);
      chk("t2_empty", 64'(out_valid), 64'd0);
      chk_cnt("t2", 3, 0);

      // bad op, too many digits, missing address
      send_str("X 12\nR 123456789\nR\n");
      chk("t3_norec", 64'(out_valid), 64'd0);
      chk_cnt("t3", 3, 3);
      send_str("r 5\n");
      pop_chk("t3_recover", 1'b0, 32'h5);
      chk_cnt("t3b", 4, 3);

      // overflow with 9 lines, then ordered drain
      do_reset();
      chk_cnt("t4_rst", 0, 0);
      for (int i = 1; i <= 8; i++) send_str($sformatf("W %0h\n", i));
      chk("t4_ovf0", 64'(overflow), 64'd0);
      send_str("W 9\n");
      chk("t4_ovf1", 64'(overflow), 64'd1);
      chk_cnt("t4", 8, 0);
      for (int i = 1; i <= 8; i++) pop_chk($sformatf("t4_pop%0d", i), 1'b1, 32'(i));
      chk("t4_empty", 64'(out_valid), 64'd0);

      // full FIFO, commit coinciding with pop is accepted
      do_reset();
      for (int i = 1; i <= 8; i++) send_str($sformatf("R %0h\n", i + 16));
      send_str("R 77");
      out_ready = 1'b1;
      send_byte(8'h0A);
      out_ready = 1'b0;
      chk("t5_ovf", 64'(overflow), 64'd0);
      for (int i = 2; i <= 8; i++) pop_chk($sformatf("t5_pop%0d", i), 1'b0, 32'(i + 16));
      pop_chk("t5_last", 1'b0, 32'h77);
      chk("t5_empty", 64'(out_valid), 64'd0);
      chk_cnt("t5", 9, 0);

      // flush commits a pending line; flush in SEP drops; byte then flush same cycle
      send_str("R 0xAB");
      flush = 1'b1; step(); flush = 1'b0;
      pop_chk("t6_flush", 1'b0, 32'hAB);
      send_str("W ");
      flush = 1'b1; step(); flush = 1'b0;
      chk("t6_sep_flush", 64'(out_valid), 64'd0);
      send_str("W 1");
      in_en = 1'b1; in_byte = "F"; flush = 1'b1;
      step();
      in_en = 1'b0; flush = 1'b0;
      pop_chk("t6_same", 1'b1, 32'h1F);
      chk_cnt("t6", 11, 0);

      // reset mid-line wins over a coincident '\n'
      send_str("R 3\n");
      send_str("W 12");
      rst = 1'b1; in_en = 1'b1; in_byte = 8'h0A;
      step();
      rst = 1'b0; in_en = 1'b0;
      chk("t7_valid", 64'(out_valid), 64'd0);
      chk("t7_op", 64'(out_op), 64'd0);
      chk("t7_addr", 64'(out_addr), 64'd0);
      chk("t7_ovf", 64'(overflow), 64'd0);
      chk_cnt("t7", 0, 0);
      send_byte(8'h0A);
      chk("t7_nopartial", 64'(out_valid), 64'd0);
      send_str("R 2\n");
      pop_chk("t7_after", 1'b0, 32'h2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
